wait_buffer: RTL
================

// Module: wait_buffer
// PURPOSE
// Holds decoded instructions whose source operands are still being produced, between the
// register table (upstream) and the operand collector (downstream). Each entry stores per-operand
// ready flags and producer tags from the register table. It wakes operands on EU write-back and
// issues the oldest fully-ready entry through a valid/ready handshake.
// PARAMETERS
// WaitBufferSize  4   number of entries (>=2)
// NumTags         8   number of in-flight producer tags
// OperandsPerInst 2   source operands per instruction
// PayloadWidth    32  opaque instruction payload (opcode, dst reg, subwarp id, ...)
// TagWidth        $clog2(NumTags)  derived; tag_t = logic [TagWidth-1:0]
// PORTS
// clk_i            in   1                    clock
// rst_i            in   1                    async reset, active-high
// empty_o          out  1                    no valid entry (to fetcher)
// ins_valid_i      in   1                    decoder presents instruction
// ins_ready_o      out  1                    free entry available
// ins_tag_i        in   TagWidth             tag of this instruction's result
// ins_payload_i    in   PayloadWidth         instruction payload
// operands_ready_i in   OperandsPerInst      per-operand ready from register table
// operands_tag_i   in   OperandsPerInst*TagWidth  producer tag per operand
// eu_valid_i       in   1                    EU write-back this cycle
// eu_tag_i         in   TagWidth             tag written back
// disp_valid_o     out  1                    an entry is fully ready
// disp_ready_i     in   1                    operand collector accepts
// disp_tag_o       out  TagWidth             tag of issued entry
// disp_payload_o   out  PayloadWidth         payload of issued entry
// BEHAVIOUR
// - Reset (async, rst_i=1): all entries invalid, age matrix cleared; empty_o=1, ins_ready_o=1,
//   disp_valid_o=0, disp_tag_o/disp_payload_o=0. Reset mid-operation drops all entries, no issue.
// - Entry state: valid, ready[OperandsPerInst], optag[OperandsPerInst], tag, payload.
// - ins_ready_o = !(&valid_q); depends on registered state only, never on ins_valid_i.
// - Insert on ins_valid_i && ins_ready_o into lowest-index free entry; ready flags = operands_ready_i
//   OR (eu_valid_i && eu_tag_i == operands_tag_i[op]) (same-cycle wakeup on insert path).
// - Wakeup: every cycle eu_valid_i set ready[op] of each valid entry where optag==eu_tag_i && !ready.
//   Flags are registered: woken entry may issue the following cycle.
// - Issue: eligible = valid && &ready (registered). disp_valid_o = |eligible. Selected entry is the
//   oldest eligible per age matrix (age[i][j]=1 means i older than j); outputs from that entry,
//   combinational from flops only, no path from disp_ready_i or EU inputs.
// - Handshake: entry freed on disp_valid_o && disp_ready_i. While disp_ready_i=0 the selection may
//   change only if an older entry becomes eligible; payload of a presented entry is never modified.
// - Latency: insert with all operands ready -> disp_valid_o next cycle. EU wakeup -> issue next cycle.
// - Simultaneous insert + issue: both happen; freed slot not reusable until next cycle
//   (ins_ready_o from q). Full buffer + issue: ins_ready_o stays 0 that cycle.
// - Age update on insert: new entry younger than all currently valid; row/col of freed entry cleared.
// - empty_o = !(|valid_q).
// - Insert while !ins_ready_o is ignored (no state change); assertion flags it as protocol error.
// - Assertions: disp_valid_o stable until handshake unless older entry pre-empts; never two entries
//   with equal tag; no issue of entry with any ready=0.
// TESTING
// 1 Reset: rst_i=1 mid-traffic with 3 valid entries -> next cycle empty_o=1, ins_ready_o=1, disp_valid_o=0.
// 2 Insert tag 3, ready=2'b11, disp_ready_i=1 -> disp_valid_o=1 next cycle, disp_tag_o=3, empty_o=1 after.
// 3 Insert tag 1 ops waiting on tags 5,6; eu 5 then eu 6 on consecutive cycles -> disp_valid_o=1 the
//   cycle after eu 6, never earlier.
// 4 Insert tags 2,4 (both ready) with disp_ready_i=0 for 3 cycles -> disp_tag_o=2 held; release -> 2 then 4.
// 5 Fill all 4 entries waiting on tag 7 -> ins_ready_o=0; eu_valid_i tag 7 -> four issues oldest-first,
//   ins_ready_o=1 the cycle after first issue.
// 6 Insert with operand tag 5 while eu_valid_i tag 5 same cycle -> entry ready, issues next cycle.

Source files
------------

// File: rtl/wait_buffer.sv
// wait_buffer: holds decoded instructions until all source operands have been
// produced, wakes operands on EU write-back and issues the oldest fully-ready
// entry to the operand collector over a valid/ready handshake.
//
// Entry selection for issue is driven by an age matrix: r_age[i][j] = 1 means
// entry i was inserted before entry j. Issue outputs are decoded from flops
// only, so there is no combinational path from disp_ready_i or the EU inputs.
module wait_buffer #(
  parameter int WaitBufferSize  = 4,
  parameter int NumTags         = 8,
  parameter int OperandsPerInst = 2,
  parameter int PayloadWidth    = 32,
  // derived from NumTags; leave at its default
  parameter int TagWidth        = $clog2(NumTags)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  output logic                                empty_o,
  input  logic                                ins_valid_i,
  output logic                                ins_ready_o,
  input  logic [TagWidth-1:0]                 ins_tag_i,
  input  logic [PayloadWidth-1:0]             ins_payload_i,
  input  logic [OperandsPerInst-1:0]          operands_ready_i,
  input  logic [OperandsPerInst*TagWidth-1:0] operands_tag_i,
  input  logic                                eu_valid_i,
  input  logic [TagWidth-1:0]                 eu_tag_i,
  output logic                                disp_valid_o,
  input  logic                                disp_ready_i,
  output logic [TagWidth-1:0]                 disp_tag_o,
  output logic [PayloadWidth-1:0]             disp_payload_o
);

  localparam int IdxWidth = $clog2(WaitBufferSize);

  // Entry storage
  logic [WaitBufferSize-1:0]                                     r_valid;
  logic [WaitBufferSize-1:0][OperandsPerInst-1:0]                r_ready;
  logic [WaitBufferSize-1:0][OperandsPerInst-1:0][TagWidth-1:0]  r_optag;
  logic [WaitBufferSize-1:0][TagWidth-1:0]                       r_tag;
  logic [WaitBufferSize-1:0][PayloadWidth-1:0]                   r_payload;
  logic [WaitBufferSize-1:0][WaitBufferSize-1:0]                 r_age;

  // Control
  logic                       w_ins_fire;
  logic [IdxWidth-1:0]        w_ins_idx;
  logic [OperandsPerInst-1:0] w_ins_ready;
  logic [WaitBufferSize-1:0]  w_elig;
  logic [WaitBufferSize-1:0]  w_sel_oh;
  logic [IdxWidth-1:0]        w_sel_idx;
  logic                       w_issue;
  logic [WaitBufferSize-1:0]  w_free_oh;
  logic                       w_dup_tag;

  // Status flags come straight from the valid vector so that ins_ready_o
  // never depends on ins_valid_i; a slot freed by issue is reusable next cycle.
  assign ins_ready_o = !(&r_valid);
  assign empty_o     = !(|r_valid);
  assign w_ins_fire  = ins_valid_i && ins_ready_o;

  // Lowest-index free slot for the next insert
  always_comb begin
    w_ins_idx = '0;
    for (int i = WaitBufferSize - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_ins_idx = IdxWidth'(i);
      end
    end
  end

  // Initial ready flags of an inserted entry, including a write-back landing
  // in the same cycle as the insert
  always_comb begin
    w_ins_ready = '0;
    for (int op = 0; op < OperandsPerInst; op++) begin
      w_ins_ready[op] = operands_ready_i[op] ||
                        (eu_valid_i && (eu_tag_i == operands_tag_i[op*TagWidth +: TagWidth]));
    end
  end

  // Entries that hold every operand
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < WaitBufferSize; i++) begin
      w_elig[i] = r_valid[i] && (&r_ready[i]);
    end
  end

  // Oldest eligible entry: eligible and older than every other eligible entry
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < WaitBufferSize; i++) begin
      w_sel_oh[i] = w_elig[i] &&
                    !(|(w_elig & ~r_age[i] & ~(WaitBufferSize'(1) << i)));
    end
  end

  // One-hot to index for the output mux
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < WaitBufferSize; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_idx = IdxWidth'(i);
      end
    end
  end

  assign disp_valid_o   = |w_elig;
  assign disp_tag_o     = disp_valid_o ? r_tag[w_sel_idx]     : '0;
  assign disp_payload_o = disp_valid_o ? r_payload[w_sel_idx] : '0;
  assign w_issue        = disp_valid_o && disp_ready_i;
  assign w_free_oh      = w_issue ? w_sel_oh : '0;

  // Entry state: free on issue, load on insert, otherwise wake operands
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid   <= '0;
      r_ready   <= '0;
      r_optag   <= '0;
      r_tag     <= '0;
      r_payload <= '0;
    end else begin
      for (int i = 0; i < WaitBufferSize; i++) begin
        if (w_free_oh[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_ins_fire && (w_ins_idx == IdxWidth'(i))) begin
          r_valid[i]   <= 1'b1;
          r_ready[i]   <= w_ins_ready;
          r_tag[i]     <= ins_tag_i;
          r_payload[i] <= ins_payload_i;
          for (int op = 0; op < OperandsPerInst; op++) begin
            r_optag[i][op] <= operands_tag_i[op*TagWidth +: TagWidth];
          end
        end else if (r_valid[i] && eu_valid_i) begin
          for (int op = 0; op < OperandsPerInst; op++) begin
            if (!r_ready[i][op] && (r_optag[i][op] == eu_tag_i)) begin
              r_ready[i][op] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Age matrix: a freed entry drops out of every relation; a new entry is
  // younger than everything still valid. The insert slot is free in the
  // current state, so it never coincides with the slot being freed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < WaitBufferSize; i++) begin
        for (int j = 0; j < WaitBufferSize; j++) begin
          if (w_free_oh[i] || w_free_oh[j]) begin
            r_age[i][j] <= 1'b0;
          end else if (w_ins_fire && (w_ins_idx == IdxWidth'(i))) begin
            r_age[i][j] <= 1'b0;
          end else if (w_ins_fire && (w_ins_idx == IdxWidth'(j))) begin
            r_age[i][j] <= r_valid[i];
          end
        end
      end
    end
  end

  // Tags in flight must be unique among valid entries
  always_comb begin
    w_dup_tag = 1'b0;
    for (int i = 0; i < WaitBufferSize; i++) begin
      for (int j = i + 1; j < WaitBufferSize; j++) begin
        if (r_valid[i] && r_valid[j] && (r_tag[i] == r_tag[j])) begin
          w_dup_tag = 1'b1;
        end
      end
    end
  end

  // Upstream must not push into a full buffer
  a_ins_protocol: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ins_valid_i && !ins_ready_o));

  // A presented entry stays presented until accepted
  a_disp_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (disp_valid_o && !disp_ready_i) |=> disp_valid_o);

  // Selection only moves to an older entry while stalled
  a_disp_preempt: assert property (@(posedge clk_i) disable iff (rst_i)
    (disp_valid_o && !disp_ready_i) |=>
      ((w_sel_idx == $past(w_sel_idx)) || r_age[w_sel_idx][$past(w_sel_idx)]));

  // Payload of a held entry never changes
  a_disp_payload: assert property (@(posedge clk_i) disable iff (rst_i)
    (disp_valid_o && !disp_ready_i) |=>
      ((w_sel_idx != $past(w_sel_idx)) || (disp_payload_o == $past(disp_payload_o))));

  a_unique_tag: assert property (@(posedge clk_i) disable iff (rst_i) !w_dup_tag);

  // Never issue an entry with a missing operand
  a_issue_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    w_issue |-> (r_valid[w_sel_idx] && (&r_ready[w_sel_idx])));

endmodule
